// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the divided-clock controller.
//   ch_state_t      : per-channel state encoding (HALTED=0, RUN=1, STEP=2)
//   DEF_DIV_DEFAULT : half-period divisor loaded into every channel at reset
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } ch_state_t;

    localparam int DEF_DIV_DEFAULT = 130000;

endpackage

// File: rtl/clock_ctrl_channel.sv
// ---------------------------------------------------------------------------
// clock_ctrl_channel
// One independent divided-clock channel.
//   clk, rst   : system clock, asynchronous active-high reset
//   halt       : level halt request
//   step       : one-cycle request for a single period while halted
//   wr, wr_val : write strobe and value for the pending divisor
//   clk_out    : registered divided clock
//   tick       : pulse in the first cycle clk_out is high
//   running    : high in RUN or STEP
// A period is a low half followed by a high half, so the 1->0 toggle is the
// period boundary where a pending divisor is adopted.
// ---------------------------------------------------------------------------
module clock_ctrl_channel
    import clock_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             step,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    ch_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_act, div_act_n;
    logic [CNT_W-1:0] div_pend, div_pend_n;
    logic             clk_n, tick_n;
    logic [CNT_W-1:0] last;
    logic             at_end;

    // A divisor of zero behaves like one: the counter end value is zero.
    assign last    = (div_act == '0) ? '0 : (div_act - CNT_W'(1));
    assign at_end  = (cnt == last);
    assign running = (state == ST_RUN) || (state == ST_STEP);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_HALTED;
            cnt      <= '0;
            div_act  <= CNT_W'(DEF_DIV);
            div_pend <= CNT_W'(DEF_DIV);
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_act  <= div_act_n;
            div_pend <= div_pend_n;
            clk_out  <= clk_n;
            tick     <= tick_n;
        end
    end

    // Next-state logic. While halted the pending divisor is copied every
    // cycle; while counting it is only copied at the high->low toggle, so a
    // period never mixes two divisors.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        clk_n      = clk_out;
        tick_n     = 1'b0;
        div_act_n  = div_act;
        div_pend_n = wr ? wr_val : div_pend;

        case (state)
            ST_HALTED: begin
                cnt_n     = '0;
                clk_n     = 1'b0;
                div_act_n = div_pend;
                if (!halt) begin
                    state_n = ST_RUN;
                end else if (step) begin
                    state_n = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                // Halt aborts a running channel immediately; STEP ignores it.
                if ((state == ST_RUN) && halt) begin
                    state_n = ST_HALTED;
                    cnt_n   = '0;
                    clk_n   = 1'b0;
                end else if (at_end) begin
                    cnt_n = '0;
                    clk_n = ~clk_out;
                    if (!clk_out) begin
                        tick_n = 1'b1;
                    end else begin
                        div_act_n = div_pend;
                        if (state == ST_STEP) begin
                            state_n = halt ? ST_HALTED : ST_RUN;
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_HALTED;
                cnt_n   = '0;
                clk_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/clock_ctrl.sv
// ---------------------------------------------------------------------------
// clock_ctrl
// Multi-channel programmable clock divider.
//   i_clk, i_rst        : system clock, asynchronous active-high reset
//   i_halt, i_step      : per-channel halt level and single-period pulse
//   i_div_wr/ch/val     : divisor write strobe, target channel, half-period
//   o_div_ack           : pulse the cycle after every write strobe
//   o_clk, o_tick       : per-channel divided clock and rising-edge pulse
//   o_running           : per-channel RUN/STEP indication
// ---------------------------------------------------------------------------
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = DEF_DIV_DEFAULT,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_halt,
    input  logic [NUM_CH-1:0] i_step,
    input  logic              i_div_wr,
    input  logic [CH_W-1:0]   i_div_ch,
    input  logic [CNT_W-1:0]  i_div_val,
    output logic              o_div_ack,
    output logic [NUM_CH-1:0] o_clk,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_running
);

    logic [NUM_CH-1:0] wr_sel;

    // Write decode; a channel index past the last channel selects nothing,
    // so the write is acknowledged but discarded.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            wr_sel[n] = i_div_wr && (int'(i_div_ch) == n);
        end
    end

    // Every strobe is acknowledged one cycle later, valid channel or not.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_div_ack <= 1'b0;
        end else begin
            o_div_ack <= i_div_wr;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        clock_ctrl_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_channel (
            .clk     (i_clk),
            .rst     (i_rst),
            .halt    (i_halt[n]),
            .step    (i_step[n]),
            .wr      (wr_sel[n]),
            .wr_val  (i_div_val),
            .clk_out (o_clk[n]),
            .tick    (o_tick[n]),
            .running (o_running[n])
        );
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_ctrl
// Self-checking bench for clock_ctrl with three channels and a small default
// divisor. The reference model tracks each channel as a position within a
// period of length 2*div: the clock is high for positions div..2*div-1.
// ---------------------------------------------------------------------------
module tb_clock_ctrl;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [NCH-1:0] i_halt;
    logic [NCH-1:0] i_step;
    logic           i_div_wr;
    logic [1:0]     i_div_ch;
    logic [CW-1:0]  i_div_val;
    logic           o_div_ack;
    logic [NCH-1:0] o_clk;
    logic [NCH-1:0] o_tick;
    logic [NCH-1:0] o_running;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit             active [NCH];
    bit             single [NCH];
    int             pos    [NCH];
    int             dcur   [NCH];
    int             pend   [NCH];
    logic [NCH-1:0] exp_clk, exp_tick, exp_run;
    logic           exp_ack;

    clock_ctrl #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (DEF)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_halt    (i_halt),
        .i_step    (i_step),
        .i_div_wr  (i_div_wr),
        .i_div_ch  (i_div_ch),
        .i_div_val (i_div_val),
        .o_div_ack (o_div_ack),
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_running (o_running)
    );

    always #5 i_clk = ~i_clk;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic compute_expected();
        for (int n = 0; n < NCH; n++) begin
            exp_run[n]  = active[n];
            exp_clk[n]  = active[n] && (pos[n] >= dcur[n]);
            exp_tick[n] = active[n] && (pos[n] == dcur[n]);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            active[n] = 1'b0;
            single[n] = 1'b0;
            pos[n]    = 0;
            dcur[n]   = DEF;
            pend[n]   = DEF;
        end
        exp_ack = 1'b0;
        compute_expected();
    endtask

    // One rising edge of behaviour, using the inputs present at that edge.
    task automatic model_step();
        for (int n = 0; n < NCH; n++) begin
            if (!active[n]) begin
                pos[n]  = 0;
                dcur[n] = eff(pend[n]);
                if (!i_halt[n]) begin
                    active[n] = 1'b1;
                    single[n] = 1'b0;
                end else if (i_step[n]) begin
                    active[n] = 1'b1;
                    single[n] = 1'b1;
                end
            end else if (!single[n] && i_halt[n]) begin
                active[n] = 1'b0;
                pos[n]    = 0;
            end else begin
                pos[n]++;
                if (pos[n] == 2 * dcur[n]) begin
                    pos[n]  = 0;
                    dcur[n] = eff(pend[n]);
                    if (single[n]) begin
                        single[n] = 1'b0;
                        active[n] = !i_halt[n];
                    end
                end
            end
        end
        if (i_div_wr && (int'(i_div_ch) < NCH)) begin
            pend[int'(i_div_ch)] = int'(i_div_val);
        end
        exp_ack = i_div_wr;
        compute_expected();
    endtask

    task automatic check_output();
        checks++;
        assert (o_clk === exp_clk) else begin
            errors++;
            $error("[TB] FAIL o_clk observed=%b expected=%b", o_clk, exp_clk);
        end
        checks++;
        assert (o_tick === exp_tick) else begin
            errors++;
            $error("[TB] FAIL o_tick observed=%b expected=%b", o_tick, exp_tick);
        end
        checks++;
        assert (o_running === exp_run) else begin
            errors++;
            $error("[TB] FAIL o_running observed=%b expected=%b", o_running, exp_run);
        end
        checks++;
        assert (o_div_ack === exp_ack) else begin
            errors++;
            $error("[TB] FAIL o_div_ack observed=%b expected=%b", o_div_ack, exp_ack);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic run_cycle();
        @(posedge i_clk);
        if (i_rst) model_reset();
        else model_step();
        @(negedge i_clk);
        check_output();
    endtask

    task automatic apply_stimulus(input logic [NCH-1:0] halt, input logic [NCH-1:0] step,
                                  input logic wr, input int ch, input int val);
        i_halt    = halt;
        i_step    = step;
        i_div_wr  = wr;
        i_div_ch  = 2'(ch);
        i_div_val = CW'(val);
        run_cycle();
        i_step    = '0;
        i_div_wr  = 1'b0;
    endtask

    initial begin
        int first_tick;
        int second_tick;
        int ticks;
        int highs;
        logic [NCH-1:0] h;
        logic [NCH-1:0] s;

        i_rst     = 1'b1;
        i_halt    = '1;
        i_step    = '0;
        i_div_wr  = 1'b0;
        i_div_ch  = '0;
        i_div_val = '0;
        model_reset();
        run_cycle();
        run_cycle();
        i_rst = 1'b0;

        // Channel 0 free-running at the default divisor.
        $display("[TB] free run at default divisor");
        first_tick  = -1;
        second_tick = -1;
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(3'b110, '0, 1'b0, 0, 0);
            if (o_tick[0] === 1'b1) begin
                if (first_tick < 0) first_tick = i;
                else if (second_tick < 0) second_tick = i;
            end
        end
        check_int("ch0_period", second_tick - first_tick, 2 * DEF);

        // Halt two cycles into a high half.
        $display("[TB] halt mid high half");
        for (int i = 0; i < 20 && o_tick[0] !== 1'b1; i++) run_cycle();
        check_int("ch0_wait_rise", int'(o_tick[0]), 1);
        run_cycle();
        apply_stimulus(3'b111, '0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle();

        // Single period on halted channel 2 with divisor 3.
        $display("[TB] single step");
        apply_stimulus(3'b111, '0, 1'b1, 2, 3);
        run_cycle();
        apply_stimulus(3'b111, 3'b100, 1'b0, 0, 0);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle();
            if (o_tick[2] === 1'b1) ticks++;
            if (o_clk[2] === 1'b1) highs++;
        end
        check_int("ch2_step_ticks", ticks, 1);
        check_int("ch2_step_high_cycles", highs, 3);

        // Divisor change on channel 1 mid high half, plus out-of-range write.
        $display("[TB] divisor write while running");
        i_halt = 3'b101;
        for (int i = 0; i < 20 && o_tick[1] !== 1'b1; i++) run_cycle();
        check_int("ch1_wait_rise", int'(o_tick[1]), 1);
        apply_stimulus(3'b101, '0, 1'b1, 1, 2);
        apply_stimulus(3'b101, '0, 1'b1, 3, 1);
        i_halt = 3'b100;
        for (int i = 0; i < 20; i++) run_cycle();

        // Divisor zero on channel 0, then an asynchronous reset mid-period.
        $display("[TB] divisor zero and async reset");
        apply_stimulus(3'b100, '0, 1'b1, 0, 0);
        for (int i = 0; i < 10; i++) run_cycle();
        apply_stimulus(3'b000, '0, 1'b1, 2, 1);
        for (int i = 0; i < 3; i++) run_cycle();
        #2 i_rst = 1'b1;
        #1;
        model_reset();
        check_output();
        run_cycle();
        i_rst = 1'b0;
        for (int i = 0; i < 20; i++) apply_stimulus(3'b000, '0, 1'b0, 0, 0);

        // Randomised traffic.
        $display("[TB] random traffic");
        h = 3'b000;
        for (int i = 0; i < 800; i++) begin
            for (int n = 0; n < NCH; n++) begin
                if ($urandom_range(0, 15) == 0) h[n] = ~h[n];
                s[n] = ($urandom_range(0, 3) == 0);
            end
            apply_stimulus(h, s, ($urandom_range(0, 5) == 0),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
